seg_scan_display: RTL
=====================

// Module: seg_scan_display
// PURPOSE
//  Consumes the divided scan clock clk_N and drives an 8-digit multiplexed
//  7-segment display from a 32-bit hex value. Runs entirely in the clk domain.
//  clk_N is synchronised, and each rising edge advances the scan by one digit.
//  Data is snapshotted once per frame so a digit never shows a half-updated word.
// PARAMETERS
//  DIGITS   8   number of scanned digits; fixed at 8, and data width = 4*DIGITS
// PORTS
//  clk      in   1   system clock (100 MHz board clock)
//  rst      in   1   asynchronous, active-high reset
//  clk_N    in   1   divided scan clock level from the divider, asynchronous to use
//  data     in   32  hex value to show; digit i = data[4i+3:4i], digit 0 rightmost
//  blank    in   8   1 = digit i dark
//  dp       in   8   1 = decimal point of digit i lit
//  an       out  8   digit enables, active-low, one-hot-low while scanning
//  seg      out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp_n     out  1   decimal point, active-low
// BEHAVIOUR
//  - Reset (async, any time): sync0/sync1/prev=0, idx=0, state=OFF,
//    shadow data/blank/dp=0, an=8'hFF, seg=7'h7F, dp_n=1. Takes effect
//    immediately; no partial frame resumes after release.
//  - Edge detect: sync0<=clk_N; sync1<=sync0; prev<=sync1; step=sync1&~prev.
//    step is exactly one clk cycle wide per clk_N rising edge. Falling edges
//    and a static clk_N produce no step.
//  - Latency: clk_N rising before clk edge k -> step high after edge k+1
//    -> an/seg/dp_n change at edge k+2. All outputs are registered.
//  - FSM OFF: outputs dark; on step -> SCAN with idx=0 and a snapshot load.
//  - FSM SCAN: on step, if idx==7 then idx<=0 and snapshot load, else idx<=idx+1.
//    Without step, hold all state and outputs.
//  - Snapshot load: shadow_data<=data, shadow_blank<=blank, shadow_dp<=dp,
//    taken in the same cycle idx becomes 0. Digit 0 of the new frame already
//    uses the new values, computed from the live inputs in that cycle.
//  - Output update (on every step in SCAN, or on entry to SCAN), with n = next idx:
//    if blank_n: an<=8'hFF, seg<=7'h7F, dp_n<=1;
//    else: an<=~(8'b1<<n), seg<=hex(nibble n), dp_n<=~dp_n_bit.
//  - Mid-frame changes on data/blank/dp are invisible until the next frame.
//  - hex() decode, active-low {g..a}: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//    8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
//  - idx is 3 bits and wraps 7->0 only through the SCAN rule; no other values are reachable.
//  - Simultaneous rst and step: rst wins.
// TESTING
//  1. rst=1, then release with clk_N=0 static for 1000 clk
//     -> an=FF, seg=7F, dp_n=1 throughout.
//  2. data=32'h89AB_CDEF, blank=0, dp=0, 8 clk_N rising edges
//     -> an sequence FE,FD,...,7F with seg 0E,06,21,46,03,08,10,00;
//     each change occurs exactly 3 clk edges after its clk_N edge.
//  3. Change data to 32'h0000_0001 while idx=3
//     -> digits 4..7 keep the 89AB values; the next frame's digit 0 shows 79.
//  4. blank=8'h0F, dp=8'h10, data=0
//     -> digits 0-3: an=FF, seg=7F; digit 4: an=EF, seg=40, dp_n=0.
//  5. clk_N toggled with 1-clk glitch-free pulses and held high for 50 clk
//     -> exactly one step per rising edge; none on the falling edge.
//  6. Assert rst for 1 cycle while idx=5 mid-frame
//     -> outputs dark immediately; the next clk_N edge shows digit 0.

Source files
------------

// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_display: the scan clock level, the word to show
// and its per-digit attributes, plus the multiplexed active-low drive lines.
interface seg_scan_if;
    logic        clk_N;
    logic [31:0] data;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    modport master (
        output clk_N, data, blank, dp,
        input  an, seg, dp_n
    );

    modport slave (
        input  clk_N, data, blank, dp,
        output an, seg, dp_n
    );
endinterface

// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed 7-segment scanner. The divided scan clock is synchronised
// and its rising edges step the scan; data is snapshotted once per frame.
module seg_scan_display #(
    parameter int DIGITS = 8
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic {OFF, SCAN} state_t;

    state_t         state;
    logic           sync0, sync1, prev;
    logic           step;
    logic [2:0]     idx;
    logic [W-1:0]   shadow_data;
    logic [7:0]     shadow_blank;
    logic [7:0]     shadow_dp;

    logic           wrap;
    logic [2:0]     nidx;
    logic [W-1:0]   src_data;
    logic [7:0]     src_blank;
    logic [7:0]     src_dp;
    logic [3:0]     nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign step = sync1 & ~prev;

    // Digit 0 of a new frame reads the live inputs, since the shadow loads on the same edge.
    always_comb begin
        wrap      = (state == OFF) || (idx == 3'd7);
        nidx      = wrap ? 3'd0 : idx + 3'd1;
        src_data  = wrap ? bus.data  : shadow_data;
        src_blank = wrap ? bus.blank : shadow_blank;
        src_dp    = wrap ? bus.dp    : shadow_dp;
        nib       = src_data[{nidx, 2'b00} +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0        <= 1'b0;
            sync1        <= 1'b0;
            prev         <= 1'b0;
            state        <= OFF;
            idx          <= 3'd0;
            shadow_data  <= '0;
            shadow_blank <= '0;
            shadow_dp    <= '0;
            bus.an       <= 8'hFF;
            bus.seg      <= 7'h7F;
            bus.dp_n     <= 1'b1;
        end else begin
            sync0 <= bus.clk_N;
            sync1 <= sync0;
            prev  <= sync1;
            if (step) begin
                state <= SCAN;
                idx   <= nidx;
                if (wrap) begin
                    shadow_data  <= bus.data;
                    shadow_blank <= bus.blank;
                    shadow_dp    <= bus.dp;
                end
                if (src_blank[nidx]) begin
                    bus.an   <= 8'hFF;
                    bus.seg  <= 7'h7F;
                    bus.dp_n <= 1'b1;
                end else begin
                    bus.an   <= ~(8'b1 << nidx);
                    bus.seg  <= hex7(nib);
                    bus.dp_n <= ~src_dp[nidx];
                end
            end
        end
    end
endmodule
